// File: rtl/clock_divider_prog.sv
// Programmable clock divider: square-wave clock_out plus one-cycle tick, divisor reloaded at period boundaries.
// Latency: outputs registered, one clock_in edge after the deciding inputs; no flow control (free-running when enabled).
// Optional saturating terminal-event counter on wrap_count when CLOCK_DIVIDER_PROG_WRAPCNT_EN is defined.
module clock_divider_prog #(
  parameter int          WIDTH       = 28,
  parameter int unsigned DEFAULT_DIV = 25000
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  output logic             clock_out,
  output logic             tick,
`ifdef CLOCK_DIVIDER_PROG_WRAPCNT_EN
  output logic [15:0]      wrap_count,
`endif
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] div_active
);

  localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);

  logic [WIDTH-1:0] pending;
  logic             pending_vld;
  logic             term;

  // >= rather than == so a divisor shrunk below the running count ends the period at once
  assign term = enable && (count >= div_active);

  always_ff @(posedge clock_in) begin
    if (reset) begin
      count       <= '0;
      clock_out   <= 1'b0;
      tick        <= 1'b0;
      div_active  <= DEF_DIV;
      pending     <= '0;
      pending_vld <= 1'b0;
    end else if (clear) begin
      count     <= '0;
      clock_out <= 1'b0;
      tick      <= 1'b0;
    end else if (enable) begin
      if (term) begin
        count       <= '0;
        clock_out   <= ~clock_out;
        tick        <= 1'b1;
        pending_vld <= 1'b0;
        if (div_load)
          div_active <= div_in;
        else if (pending_vld)
          div_active <= pending;
      end else begin
        count <= count + 1'b1;
        tick  <= 1'b0;
        if (div_load) begin
          pending     <= div_in;
          pending_vld <= 1'b1;
        end
      end
    end else begin
      // Stopped counter has no boundary to wait for, so a load takes effect immediately
      tick <= 1'b0;
      if (div_load) begin
        div_active  <= div_in;
        pending_vld <= 1'b0;
      end
    end
  end

`ifdef CLOCK_DIVIDER_PROG_WRAPCNT_EN
  always_ff @(posedge clock_in) begin
    if (reset || clear)
      wrap_count <= '0;
    else if (term && (wrap_count != 16'hFFFF))
      wrap_count <= wrap_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_clock_divider_prog.sv
// Randomised and directed bench for clock_divider_prog against an in-bench behavioural model.
module tb_clock_divider_prog;

  localparam int W = 4;
  localparam int DEF = 4;

  logic         clock_in = 1'b0;
  logic         reset = 1'b1;
  logic         enable = 1'b0;
  logic         clear = 1'b0;
  logic [W-1:0] div_in = '0;
  logic         div_load = 1'b0;
  logic         clock_out;
  logic         tick;
  logic [W-1:0] count;
  logic [W-1:0] div_active;
`ifdef CLOCK_DIVIDER_PROG_WRAPCNT_EN
  logic [15:0]  wrap_count;
`endif

  clock_divider_prog #(.WIDTH(W), .DEFAULT_DIV(DEF)) dut (
    .clock_in   (clock_in),
    .reset      (reset),
    .enable     (enable),
    .clear      (clear),
    .div_in     (div_in),
    .div_load   (div_load),
    .clock_out  (clock_out),
    .tick       (tick),
`ifdef CLOCK_DIVIDER_PROG_WRAPCNT_EN
    .wrap_count (wrap_count),
`endif
    .count      (count),
    .div_active (div_active)
  );

  always #5 clock_in = ~clock_in;

  int errors = 0;
  int checks = 0;
  bit chk_on = 0;

  // Behavioural model: the period in progress, the divisor governing it and the queued next divisor
  int m_cnt, m_out, m_tick, m_div, m_pend, m_pv, m_wrap;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model(input bit r, input bit c, input bit e, input bit l, input int d);
    if (r) begin
      m_cnt = 0; m_out = 0; m_tick = 0; m_div = DEF; m_pend = 0; m_pv = 0; m_wrap = 0;
    end else if (c) begin
      m_cnt = 0; m_out = 0; m_tick = 0; m_wrap = 0;
    end else if (!e) begin
      m_tick = 0;
      if (l) begin m_div = d; m_pv = 0; end
    end else if (m_cnt >= m_div) begin
      // Period ends: next period's divisor is this cycle's load, else the queued one, else unchanged
      m_div  = l ? d : (m_pv ? m_pend : m_div);
      m_pv   = 0;
      m_cnt  = 0;
      m_out  = 1 - m_out;
      m_tick = 1;
      m_wrap = (m_wrap < 65535) ? m_wrap + 1 : 65535;
    end else begin
      m_cnt  = m_cnt + 1;
      m_tick = 0;
      if (l) begin m_pend = d; m_pv = 1; end
    end
  endtask

  task automatic step(input bit r, input bit c, input bit e, input bit l, input int d);
    reset = r; clear = c; enable = e; div_load = l; div_in = W'(d);
    @(posedge clock_in);
    model(r, c, e, l, d);
    chk_on = 1;
    @(negedge clock_in);
    #1;
  endtask

  always @(negedge clock_in) begin
    if (chk_on) begin
      check("count", int'(count), m_cnt);
      check("clock_out", int'(clock_out), m_out);
      check("tick", int'(tick), m_tick);
      check("div_active", int'(div_active), m_div);
`ifdef CLOCK_DIVIDER_PROG_WRAPCNT_EN
      check("wrap_count", int'(wrap_count), m_wrap);
`endif
    end
  end

  initial begin
    step(1, 0, 0, 0, 0);
    check("lit_reset_count", int'(count), 0);
    check("lit_reset_div", int'(div_active), DEF);
    check("lit_reset_clk", int'(clock_out), 0);

    // Default divisor: ticks on cycles 5, 10, 15 after release
    for (int k = 1; k <= 15; k++) begin
      step(0, 0, 1, 0, 0);
      if (k == 3)  check("lit_cnt3", int'(count), 3);
      if (k == 4)  check("lit_cnt4_notick", int'(tick), 0);
      if (k == 5)  begin check("lit_tick5", int'(tick), 1); check("lit_clk5", int'(clock_out), 1); end
      if (k == 6)  check("lit_tick6", int'(tick), 0);
      if (k == 10) begin check("lit_tick10", int'(tick), 1); check("lit_clk10", int'(clock_out), 0); end
      if (k == 15) check("lit_tick15", int'(tick), 1);
    end

    // Load 2 mid-period: current period still ends at count 4
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 1, 2);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    check("lit_div_still4", int'(div_active), 4);
    check("lit_cnt_at4", int'(count), 4);
    step(0, 0, 1, 0, 0);
    check("lit_div_now2", int'(div_active), 2);
    check("lit_tick_old_end", int'(tick), 1);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    check("lit_short_notick", int'(tick), 0);
    step(0, 0, 1, 0, 0);
    check("lit_short_tick", int'(tick), 1);

    // Load 0 exactly at the terminal cycle
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 1, 0);
    check("lit_div0", int'(div_active), 0);
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 1, 0, 0);
      check("lit_div0_tick", int'(tick), 1);
    end

    // Hold while disabled, then a load below the held count fires at once
    step(0, 0, 0, 1, 4);
    for (int k = 0; k < 3; k++) step(0, 0, 1, 0, 0);
    check("lit_hold_cnt", int'(count), 3);
    for (int k = 0; k < 10; k++) step(0, 0, 0, 0, 0);
    check("lit_held_cnt", int'(count), 3);
    check("lit_held_tick", int'(tick), 0);
    step(0, 0, 0, 1, 1);
    check("lit_imm_div", int'(div_active), 1);
    check("lit_imm_cnt", int'(count), 3);
    step(0, 0, 1, 0, 0);
    check("lit_imm_tick", int'(tick), 1);

    // Clear at count 3 with clock_out high
    step(0, 0, 0, 1, 4);
    for (int k = 0; k < 40 && !(m_cnt == 3 && m_out == 1); k++) step(0, 0, 1, 0, 0);
    check("lit_pre_clear_cnt", int'(count), 3);
    step(0, 1, 1, 0, 0);
    check("lit_clear_clk", int'(clock_out), 0);
    check("lit_clear_div", int'(div_active), 4);
    for (int k = 1; k <= 5; k++) step(0, 0, 1, 0, 0);
    check("lit_clear_tick5", int'(tick), 1);

    // Reset discards a pending load
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 1, 7);
    step(1, 0, 1, 0, 0);
    check("lit_rst_div", int'(div_active), DEF);
    for (int k = 1; k <= 5; k++) step(0, 0, 1, 0, 0);
    check("lit_rst_tick5", int'(tick), 1);
    check("lit_rst_div_after", int'(div_active), DEF);

    for (int k = 0; k < 3000; k++)
      step($urandom_range(0, 199) == 0, $urandom_range(0, 49) == 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
           int'($urandom_range(0, 15)));

`ifdef CLOCK_DIVIDER_PROG_WRAPCNT_EN
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    for (int k = 0; k < 70000; k++) step(0, 0, 1, 0, 0);
    check("lit_wrap_sat", int'(wrap_count), 65535);
    step(0, 1, 1, 0, 0);
    check("lit_wrap_clear", int'(wrap_count), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
